// File: rtl/mastermind_judge.sv
// Mastermind judge: latches a secret code from the LFSR and scores guesses.
// Optional build macro MASTERMIND_REVEAL_EN exposes the code after a game ends.
module mastermind_judge #(
  parameter int MAX_GUESSES = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] random,
  input  logic       start,
  input  logic [7:0] guess,
  input  logic       submit,
  output logic [2:0] exact,
  output logic [2:0] partial,
  output logic       score_valid,
  output logic [3:0] guesses_used,
  output logic       playing,
  output logic       win,
  output logic       lose,
  output logic [7:0] secret
);

  typedef enum logic [2:0] {
    IDLE,
    PLAY,
    SCORE,
    WIN,
    LOSE
  } state_t;

  state_t state, state_n;

  logic       start_q;
  logic       submit_q;
  logic [7:0] code;
  logic [7:0] guess_q;

  logic       start_edge;
  logic       submit_edge;
  logic [2:0] exact_c;
  logic [2:0] partial_c;
  logic [2:0] total_c;
  logic [2:0] n_code  [4];
  logic [2:0] n_guess [4];
  logic [3:0] used_n;

  assign start_edge  = start && !start_q;
  assign submit_edge = submit && !submit_q;
  assign used_n      = guesses_used + 4'd1;

  // Peg scoring of the latched guess against the code
  always_comb begin
    exact_c = 3'd0;
    total_c = 3'd0;
    for (int c = 0; c < 4; c++) begin
      n_code[c]  = 3'd0;
      n_guess[c] = 3'd0;
    end
    for (int i = 0; i < 4; i++) begin
      if (code[2*i +: 2] == guess_q[2*i +: 2])
        exact_c = exact_c + 3'd1;
      n_code[code[2*i +: 2]]     = n_code[code[2*i +: 2]] + 3'd1;
      n_guess[guess_q[2*i +: 2]] = n_guess[guess_q[2*i +: 2]] + 3'd1;
    end
    for (int c = 0; c < 4; c++) begin
      if (n_code[c] < n_guess[c])
        total_c = total_c + n_code[c];
      else
        total_c = total_c + n_guess[c];
    end
    partial_c = total_c - exact_c;
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_n;
  end

  // Next-state logic; a start edge overrides everything
  always_comb begin
    state_n = state;
    if (start_edge) begin
      state_n = PLAY;
    end else begin
      unique case (state)
        PLAY:
          if (submit_edge)
            state_n = SCORE;
        SCORE:
          if (exact_c == 3'd4)
            state_n = WIN;
          else if (used_n == 4'(MAX_GUESSES))
            state_n = LOSE;
          else
            state_n = PLAY;
        default:
          state_n = state;
      endcase
    end
  end

  // Edge detectors, code/guess capture and score registers
  always_ff @(posedge clk) begin
    if (reset) begin
      start_q      <= 1'b0;
      submit_q     <= 1'b0;
      code         <= 8'h00;
      guess_q      <= 8'h00;
      exact        <= 3'd0;
      partial      <= 3'd0;
      score_valid  <= 1'b0;
      guesses_used <= 4'd0;
    end else begin
      start_q     <= start;
      submit_q    <= submit;
      score_valid <= 1'b0;
      if (start_edge) begin
        code         <= random;
        exact        <= 3'd0;
        partial      <= 3'd0;
        guesses_used <= 4'd0;
      end else if (state == PLAY && submit_edge) begin
        guess_q <= guess;
      end else if (state == SCORE) begin
        exact        <= exact_c;
        partial      <= partial_c;
        score_valid  <= 1'b1;
        guesses_used <= used_n;
      end
    end
  end

  assign playing = (state == PLAY) || (state == SCORE);
  assign win     = (state == WIN);
  assign lose    = (state == LOSE);

`ifdef MASTERMIND_REVEAL_EN
  assign secret = (win || lose) ? code : 8'h00;
`else
  assign secret = 8'h00;
`endif

endmodule

// File: tb/tb_mastermind_judge.sv
// Self-checking bench for mastermind_judge: vector table, directed
// corner sequences and randomized games against a pairing model.
module tb_mastermind_judge;

  localparam int MAXG = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] random;
  logic       start;
  logic [7:0] guess;
  logic       submit;
  logic [2:0] exact;
  logic [2:0] partial;
  logic       score_valid;
  logic [3:0] guesses_used;
  logic       playing;
  logic       win;
  logic       lose;
  logic [7:0] secret;

  int vectors = 0;
  int miscompares = 0;

  mastermind_judge #(.MAX_GUESSES(MAXG)) dut (
    .clk(clk),
    .reset(reset),
    .random(random),
    .start(start),
    .guess(guess),
    .submit(submit),
    .exact(exact),
    .partial(partial),
    .score_valid(score_valid),
    .guesses_used(guesses_used),
    .playing(playing),
    .win(win),
    .lose(lose),
    .secret(secret)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] code;
    logic [7:0] g;
    int         ex;
    int         pa;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Classic pairing: exact pegs consume digits, then each remaining
  // guess digit claims one unused code digit of the same colour.
  task automatic model(input logic [7:0] c, input logic [7:0] g,
                       output int ex, output int pa);
    bit cu[4];
    bit gu[4];
    logic [1:0] cd[4];
    logic [1:0] gd[4];
    ex = 0;
    pa = 0;
    for (int i = 0; i < 4; i++) begin
      cd[i] = c[2*i +: 2];
      gd[i] = g[2*i +: 2];
      cu[i] = (cd[i] == gd[i]);
      gu[i] = cu[i];
      if (cu[i]) ex++;
    end
    for (int i = 0; i < 4; i++) begin
      if (!gu[i]) begin
        for (int j = 0; j < 4; j++) begin
          if (!gu[i] && !cu[j] && cd[j] == gd[i]) begin
            cu[j] = 1'b1;
            gu[i] = 1'b1;
            pa++;
          end
        end
      end
    end
  endtask

  function automatic int exp_secret(input logic [7:0] c, input bit over);
`ifdef MASTERMIND_REVEAL_EN
    return over ? int'(c) : 0;
`else
    return 0;
`endif
  endfunction

  task automatic do_start(input logic [7:0] r);
    random = r;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    random = 8'($urandom);
  endtask

  // Returns at the negedge where score_valid should be high.
  task automatic do_submit(input logic [7:0] g);
    guess  = g;
    submit = 1'b1;
    @(negedge clk);
    submit = 1'b0;
    @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " exact"}, exact, 0);
    chk({tag, " partial"}, partial, 0);
    chk({tag, " score_valid"}, score_valid, 0);
    chk({tag, " guesses_used"}, guesses_used, 0);
    chk({tag, " playing"}, playing, 0);
    chk({tag, " win"}, win, 0);
    chk({tag, " lose"}, lose, 0);
    chk({tag, " secret"}, secret, 0);
  endtask

  vec_t tbl[6];

  initial begin
    int ex, pa, used;
    logic [7:0] code, g;
    bit won;

    tbl[0] = '{8'h1B, 8'h1B, 4, 0};
    tbl[1] = '{8'h1B, 8'hE4, 0, 4};
    tbl[2] = '{8'h1B, 8'h00, 1, 0};
    tbl[3] = '{8'h1B, 8'h1E, 2, 2};
    tbl[4] = '{8'h00, 8'h05, 2, 0};
    tbl[5] = '{8'hFF, 8'hFC, 3, 0};

    reset = 1'b1; random = 8'h00; start = 1'b0;
    guess = 8'h00; submit = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_reset_vals("reset");
    reset = 1'b0;
    @(negedge clk);

    // Table: one fresh game per vector, first guess scored
    foreach (tbl[k]) begin
      do_start(tbl[k].code);
      chk("tbl playing", playing, 1);
      chk("tbl cleared", guesses_used, 0);
      do_submit(tbl[k].g);
      chk("tbl exact", exact, tbl[k].ex);
      chk("tbl partial", partial, tbl[k].pa);
      chk("tbl valid", score_valid, 1);
      chk("tbl used", guesses_used, 1);
      chk("tbl win", win, tbl[k].ex == 4 ? 1 : 0);
      chk("tbl secret", secret, exp_secret(tbl[k].code, tbl[k].ex == 4));
      @(negedge clk);
      chk("tbl pulse once", score_valid, 0);
    end

    // Lose after MAXG wrong guesses; extra submit ignored
    do_start(8'h1B);
    for (int n = 1; n <= MAXG; n++) begin
      do_submit(8'hFF);
      chk("lose exact", exact, 1);
      chk("lose partial", partial, 0);
      chk("lose valid", score_valid, 1);
      chk("lose used", guesses_used, n);
    end
    chk("lose flag", lose, 1);
    chk("lose playing", playing, 0);
    chk("lose secret", secret, exp_secret(8'h1B, 1));
    guess = 8'hFF; submit = 1'b1;
    @(negedge clk);
    submit = 1'b0;
    chk("ninth valid a", score_valid, 0);
    @(negedge clk);
    chk("ninth valid b", score_valid, 0);
    chk("ninth used", guesses_used, MAXG);
    chk("ninth lose", lose, 1);

    // Start and submit edges in the same cycle: start wins
    do_start(8'h1B);
    do_submit(8'h00);
    chk("prio pre used", guesses_used, 1);
    random = 8'hAA; start = 1'b1; guess = 8'hAA; submit = 1'b1;
    @(negedge clk);
    start = 1'b0; submit = 1'b0; random = 8'h55;
    chk("prio playing", playing, 1);
    chk("prio used", guesses_used, 0);
    chk("prio exact", exact, 0);
    chk("prio valid", score_valid, 0);
    @(negedge clk);
    chk("prio valid b", score_valid, 0);
    chk("prio still playing", playing, 1);
    do_submit(8'hAA);
    chk("prio newcode exact", exact, 4);
    chk("prio newcode win", win, 1);

    // Reset while in SCORE: no pulse, everything back to reset values
    do_start(8'h1B);
    guess = 8'hE4; submit = 1'b1;
    @(negedge clk);
    submit = 1'b0; reset = 1'b1;
    @(negedge clk);
    chk_reset_vals("rst_score");
    reset = 1'b0;
    @(negedge clk);
    chk("rst_score after", score_valid, 0);

    // Random games against the pairing model
    for (int gm = 0; gm < 40; gm++) begin
      code = 8'($urandom);
      do_start(code);
      used = 0;
      won = 1'b0;
      while (!won && used < MAXG) begin
        g = ($urandom_range(3) == 0) ? code : 8'($urandom);
        model(code, g, ex, pa);
        do_submit(g);
        used++;
        won = (ex == 4);
        chk("rnd exact", exact, ex);
        chk("rnd partial", partial, pa);
        chk("rnd valid", score_valid, 1);
        chk("rnd used", guesses_used, used);
        chk("rnd win", win, won ? 1 : 0);
        chk("rnd lose", lose, (!won && used == MAXG) ? 1 : 0);
        chk("rnd secret", secret,
            exp_secret(code, won || used == MAXG));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
